// File: rtl/ntt_poly_unpack_reader.sv
// ntt_poly_unpack_reader: reads the packed NTT-domain poly buffer and streams single coefficients
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   start           one-cycle pulse, begins a full-buffer read (honoured only when idle)
//   busy, done      run in progress; one-cycle completion pulse
//   mem_rad         registered buffer read address
//   mem_rdata       buffer read data
//   coeff_valid/ready, coeff_data, coeff_idx, poly_idx   coefficient stream with indices
//   range_err, err_idx   sticky out-of-range flag and first offending index
//                        (only with NTT_POLY_UNPACK_RANGE_CHK_EN)
module ntt_poly_unpack_reader #(
    parameter int KYBER_K         = 2,
    parameter int KYBER_N         = 256,
    parameter int KYBER_Q         = 3329,
    parameter int COEFF_W         = 12,
    parameter int COEFFS_PER_WORD = 8,
    parameter int WORD_W          = COEFF_W * COEFFS_PER_WORD,
    parameter int ADDR_W          = 6,
    parameter int RD_LATENCY      = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  mem_rad,
    input  logic [WORD_W-1:0]  mem_rdata,
    output logic               coeff_valid,
    input  logic               coeff_ready,
    output logic [COEFF_W-1:0] coeff_data,
    output logic [7:0]         coeff_idx,
    output logic               poly_idx
`ifdef NTT_POLY_UNPACK_RANGE_CHK_EN
    ,
    output logic               range_err,
    output logic [8:0]         err_idx
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EMIT, S_DONE} state_t;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(KYBER_K * KYBER_N / COEFFS_PER_WORD - 1);
    state_t state;
    logic [WORD_W-1:0] word;
    logic [2:0] lane;
    logic [7:0] wcnt;
    logic hs;
    assign hs = coeff_valid && coeff_ready;
    // Lane 0 sits in the MSBs of the word.
    assign coeff_data = COEFF_W'(word >> (COEFF_W * (COEFFS_PER_WORD - 1 - int'(lane))));
    assign coeff_idx = {mem_rad[ADDR_W-2:0], lane};
    assign poly_idx = mem_rad[ADDR_W-1];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            coeff_valid <= 1'b0;
            mem_rad     <= '0;
            word        <= '0;
            lane        <= '0;
            wcnt        <= '0;
`ifdef NTT_POLY_UNPACK_RANGE_CHK_EN
            range_err   <= 1'b0;
            err_idx     <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mem_rad <= '0;
                    lane    <= '0;
                    wcnt    <= '0;
                    busy    <= 1'b1;
                    state   <= S_WAIT;
`ifdef NTT_POLY_UNPACK_RANGE_CHK_EN
                    range_err <= 1'b0;
                    err_idx   <= '0;
`endif
                end
                // Address was presented on entry; data is settled after RD_LATENCY+1 cycles.
                S_WAIT: if (wcnt == 8'(RD_LATENCY)) begin
                    word        <= mem_rdata;
                    coeff_valid <= 1'b1;
                    wcnt        <= '0;
                    state       <= S_EMIT;
                end else begin
                    wcnt <= wcnt + 8'd1;
                end
                S_EMIT: if (hs) begin
`ifdef NTT_POLY_UNPACK_RANGE_CHK_EN
                    if (coeff_data >= COEFF_W'(KYBER_Q)) begin
                        range_err <= 1'b1;
                        if (!range_err) err_idx <= {poly_idx, coeff_idx};
                    end
`endif
                    lane <= lane + 3'd1;
                    if (lane == 3'd7) begin
                        coeff_valid <= 1'b0;
                        if (mem_rad == LAST_ADDR) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            mem_rad <= mem_rad + 1'b1;
                            state   <= S_WAIT;
                        end
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/ntt_poly_unpack_reader.md
Name: ntt_poly_unpack_reader

Overview:
- Consumer side of the packed NTT-domain polynomial buffer. The forward-NTT stage fills this buffer with 64 words of 96 bits: KYBER_K=2 polys, 32 words per poly, 8 × 12-bit coefficients per word, coefficient 0 in the MSBs.
- This block reads the buffer back and unpacks each word into single coefficients. Coefficients go out on a valid/ready stream, in natural order, with poly and coefficient indices.
- Downstream consumers are the pointwise-multiply and INTT load stages.

Parameters:
- KYBER_K, 2, number of polynomials in the buffer
- KYBER_N, 256, coefficients per polynomial
- KYBER_Q, 3329, modulus; used only by the optional range check
- COEFF_W, 12, bits per packed coefficient
- COEFFS_PER_WORD, 8, coefficients per buffer word
- WORD_W, 96, COEFF_W*COEFFS_PER_WORD
- ADDR_W, 6, buffer address width; covers KYBER_K*KYBER_N/COEFFS_PER_WORD = 64 words
- RD_LATENCY, 1, buffer read latency in cycles, counted from the edge that presents the address

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse; begins a full-buffer read; honoured only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final coefficient handshake
- mem_rad  out  ADDR_W  registered buffer read address
- mem_rdata  in  WORD_W  buffer read data
- coeff_valid  out  1  coefficient available
- coeff_ready  in  1  downstream accepts
- coeff_data  out  COEFF_W  unpacked coefficient
- coeff_idx  out  8  coefficient index within its poly, 0..255
- poly_idx  out  1  poly index, 0..KYBER_K-1

Behaviour:
- Reset values (sync, on rst_n=0): state IDLE; busy=0, done=0, coeff_valid=0, mem_rad=0, coeff_data=0, coeff_idx=0, poly_idx=0; word register and lane counter cleared.
- Reset mid-operation aborts immediately. No done pulse. Next start begins again at word 0.
- States:
  - IDLE: start=1 → mem_rad<=0, lane<=0, busy<=1, go to WAIT. start=0 → stay.
  - WAIT: stays RD_LATENCY+1 cycles, then latches mem_rdata into the word register, sets coeff_valid<=1, goes to EMIT.
  - EMIT: on each coeff_valid&&coeff_ready, lane<=lane+1.
    - After the handshake of lane 7, if mem_rad != 63: mem_rad<=mem_rad+1, lane<=0, coeff_valid<=0, go to WAIT.
    - After the handshake of lane 7, if mem_rad == 63: coeff_valid<=0, go to DONE.
  - DONE: done=1 and busy<=0 for exactly one cycle, then IDLE.
- Unpacking: coeff_data = word[WORD_W-1-COEFF_W*lane -: COEFF_W], so lane 0 = bits [95:84] and lane 7 = bits [11:0]. Passed through unsigned, no reduction.
- Indices: coeff_idx = {mem_rad[4:0], lane[2:0]}; poly_idx = mem_rad[5].
- Handshake: while coeff_valid=1 and coeff_ready=0, coeff_data, coeff_idx and poly_idx hold stable. coeff_valid never drops without a handshake. No combinational path from coeff_ready to coeff_valid.
- Throughput with coeff_ready held high: 8 consecutive valid cycles, then RD_LATENCY+1 bubble cycles per word.
- Timing at default latency, start sampled in cycle 0:
  - first coeff_valid in cycle 3
  - last handshake in cycle 640
  - done in cycle 641
- start while busy is ignored. start in the DONE cycle is ignored.
- mem_rad only changes at word boundaries and stays stable through WAIT.

Optional Feature:
- Macro: NTT_POLY_UNPACK_RANGE_CHK_EN.
- Defined:
  - Adds output range_err (1 bit) and err_idx (9 bits, {poly_idx, coeff_idx}).
  - On any handshake with coeff_data >= KYBER_Q, range_err is set and stays set (sticky).
  - err_idx captures the first offending index only.
  - Both are cleared on reset and when start is accepted.
  - Data flow is unaffected.
- Undefined: the ports and comparator are absent; behaviour is otherwise identical.

Test Plan:
- Buffer word w = {8 lanes of (w*8+k)}, coeff_ready=1, start in cycle 0 → coeff_data = 0,1,…,511 masked to 12 bits; poly_idx flips at coefficient 256; first valid in cycle 3; done is a single pulse in cycle 641.
- Word 0 = 96'h00100200300400500600700 8-style pattern with lanes 0x001..0x008 → coeff_data order 0x001,0x002,…,0x008, confirming lane 0 comes from bits [95:84].
- Random coeff_ready (about 40% high) → data and indices stable while stalled; all 512 values delivered in order, none duplicated; mem_rad never changes mid-word.
- rst_n low for 1 cycle mid-word 20 → all outputs at reset values next cycle, no done pulse; a new start replays from coefficient 0 of poly 0.
- start pulsed again in cycle 100 and in the done cycle → ignored; exactly one done pulse; the next start in IDLE runs normally.
- With NTT_POLY_UNPACK_RANGE_CHK_EN: word 40 lane 3 = 3329, word 50 lane 0 = 4095 → range_err set at that handshake, err_idx = {1, 8'd67}, not overwritten by the second violation; cleared on the next start.
